// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the execute stage and muldiv_unit.
// The master side drives requests and the slave side returns status and result.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3_alu;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            ready;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3_alu, operand1, operand2,
        input  ready, busy, result_valid, result
    );

    modport slave (
        input  start, flush, funct3_alu, operand1, operand2,
        output ready, busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit covering the RISC-V M-extension ops.
// Operates on operand magnitudes: shift-add multiply, restoring divide, and sign fix-up in FIX.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      op;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            s1;
    logic            s2;
    logic            neg1;
    logic            neg2;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] special_res;

    // Accept-time decode: signedness, magnitudes and the divide corner cases.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        s1 = 1'b0;
        s2 = 1'b0;
        unique case (bus.funct3_alu)
            3'b000, 3'b001, 3'b100, 3'b110: begin s1 = 1'b1; s2 = 1'b1; end
            3'b010:                         s1 = 1'b1;
            default:                        ;
        endcase
        accept      = bus.start & ((state == S_IDLE) | (state == S_DONE));
        neg1        = s1 & bus.operand1[XLEN-1];
        neg2        = s2 & bus.operand2[XLEN-1];
        abs1        = neg1 ? -bus.operand1 : bus.operand1;
        abs2        = neg2 ? -bus.operand2 : bus.operand2;
        div_zero    = bus.funct3_alu[2] & (bus.operand2 == '0);
        div_ovf     = bus.funct3_alu[2] & ~bus.funct3_alu[0]
                    & (bus.operand1 == MOST_NEG) & (bus.operand2 == ALL_ONES);
        special_res = bus.funct3_alu[1] ? (div_zero ? bus.operand1 : '0)
                                        : (div_zero ? ALL_ONES : bus.operand1);
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   next_hi;
    logic [XLEN-1:0]   next_lo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;

    // One iteration: multiply shifts the product right, divide shifts quotient bits in on the left.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift[XLEN-1:0] - opb;
        if (op[2]) begin
            next_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            next_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            {next_hi, next_lo} = {mul_sum, acc_lo[XLEN-1:1]};
        end

        prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_s  = neg_q ? -acc_lo : acc_lo;
        rem_s  = neg_r ? -acc_hi : acc_hi;
        unique case (op)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op    <= bus.funct3_alu;
                        neg_q <= neg1 ^ neg2;
                        neg_r <= neg1;
                        if (div_zero | div_ovf) begin
                            result_q <= special_res;
                            state    <= S_DONE;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= abs1;
                            opb    <= abs2;
                            cnt    <= CNT_W'(XLEN - 1);
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    if (cnt == '0) state <= S_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                default: begin
                    result_q <= fix_res;
                    state    <= S_DONE;
                end
            endcase
        end
    end

    assign bus.ready        = (state == S_IDLE) | (state == S_DONE);
    assign bus.busy         = (state == S_CALC) | (state == S_FIX);
    assign bus.result_valid = (state == S_DONE);
    assign bus.result       = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN = 32 and XLEN = 16, against a wide-integer reference model.
// Directed cases from the op semantics plus randomized operations, latency, flush and reset checks.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  f3;
    logic [31:0] op1;
    logic [31:0] op2;
    bit          sel16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) b32 ();
    muldiv_unit_if #(.XLEN(16)) b16 ();

    assign b32.start      = start & ~sel16;
    assign b32.flush      = flush & ~sel16;
    assign b32.funct3_alu = f3;
    assign b32.operand1   = op1;
    assign b32.operand2   = op2;
    assign b16.start      = start & sel16;
    assign b16.flush      = flush & sel16;
    assign b16.funct3_alu = f3;
    assign b16.operand1   = op1[15:0];
    assign b16.operand2   = op2[15:0];

    muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    muldiv_unit #(.XLEN(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

    logic        cur_ready, cur_busy, cur_valid;
    logic [31:0] cur_result;
    assign cur_ready  = sel16 ? b16.ready        : b32.ready;
    assign cur_busy   = sel16 ? b16.busy         : b32.busy;
    assign cur_valid  = sel16 ? b16.result_valid : b32.result_valid;
    assign cur_result = sel16 ? {16'd0, b16.result} : b32.result;

    function automatic int width();
        return sel16 ? 16 : 32;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic on wide signed values, reduced to w bits at the end.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic signed [127:0] mask, ua, ub, sa, sb, p;
        logic ovf;
        mask = (128'sd1 <<< w) - 128'sd1;
        ua = '0; ua[31:0] = a; ua = ua & mask;
        ub = '0; ub[31:0] = b; ub = ub & mask;
        sa = ua[w-1] ? ua - (128'sd1 <<< w) : ua;
        sb = ub[w-1] ? ub - (128'sd1 <<< w) : ub;
        ovf = (sa == -(128'sd1 <<< (w-1))) && (sb == -128'sd1);
        p = '0;
        case (f)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> w;
            3'd2: p = (sa * ub) >>> w;
            3'd3: p = (ua * ub) >>> w;
            3'd4: if (ub == 0) p = -128'sd1; else if (ovf) p = sa; else p = sa / sb;
            3'd5: if (ub == 0) p = -128'sd1; else p = ua / ub;
            3'd6: if (ub == 0) p = sa; else if (ovf) p = '0; else p = sa % sb;
            default: if (ub == 0) p = ua; else p = ua % ub;
        endcase
        p = p & mask;
        return p[31:0];
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b, input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        if (!f[2]) return 1'b0;
        if ((b & m) == 0) return 1'b1;
        return !f[0] && ((a & m) == (32'd1 << (w - 1))) && ((b & m) == m);
    endfunction

    // Issue one op (caller sits just after an edge), measure latency/busy, check the result.
    // junk_at >= 0 pulses a spurious start with other operands while the unit is busy.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int junk_at);
        logic [31:0] exp_r;
        int exp_lat, lat, busy_n, w;
        w = width();
        exp_r   = model(f, a, b, w);
        exp_lat = is_special(f, a, b, w) ? 0 : w + 1;
        f3 = f; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; f3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
        lat = 0;
        busy_n = cur_busy ? 1 : 0;
        while (!cur_valid && lat < 200) begin
            start = (lat == junk_at);
            @(posedge clk); #1;
            lat++;
            if (cur_busy) busy_n++;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        check({name, "_result"}, cur_result, exp_r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev, a, b, m;
        logic [2:0]  f;
        int          lat, vcount;

        reset = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; op1 = '0; op2 = '0; sel16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst32_ready", 32'(b32.ready), 32'd1);
        check("rst32_busy", 32'(b32.busy), 32'd0);
        check("rst32_valid", 32'(b32.result_valid), 32'd0);
        check("rst32_result", b32.result, 32'd0);
        check("rst16_ready", 32'(b16.ready), 32'd1);
        check("rst16_result", 32'(b16.result), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases, XLEN = 32
        run_op("mul",       3'd0, 32'h3FFF_FFFF, 32'h0000_0003, -1);
        check("mul_known",  cur_result, 32'hBFFF_FFFD);
        run_op("mulh",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("mulh_known", cur_result, 32'h0000_0000);
        run_op("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("mulhu_known", cur_result, 32'hFFFF_FFFE);
        run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'h0000_0002, -1);
        check("mulhsu_known", cur_result, 32'hFFFF_FFFF);
        run_op("div",       3'd4, 32'h3FFF_FFFF, 32'h0000_0003, -1);
        check("div_known",  cur_result, 32'h1555_5555);
        run_op("rem",       3'd6, 32'h3FFF_FFFF, 32'h0000_0003, -1);
        run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        check("div_neg_known", cur_result, 32'hFFFF_FFFD);
        run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        check("rem_neg_known", cur_result, 32'hFFFF_FFFF);
        run_op("divu",      3'd5, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        check("divu_known", cur_result, 32'h7FFF_FFFC);
        run_op("divu_zero", 3'd5, 32'h1234_5678, 32'h0000_0000, -1);
        check("divu_zero_known", cur_result, 32'hFFFF_FFFF);
        run_op("remu_zero", 3'd7, 32'h1234_5678, 32'h0000_0000, -1);
        check("remu_zero_known", cur_result, 32'h1234_5678);
        check("special_valid_held", 32'(cur_valid), 32'd1);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div_ovf_known", cur_result, 32'h8000_0000);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("rem_ovf_known", cur_result, 32'h0000_0000);

        // Spurious start during CALC cycle 5 must be ignored
        run_op("div_ignore", 3'd4, 32'h7654_3210, 32'h0000_0123, 5);
        prev = cur_result;

        // Flush at CALC cycle 10
        f3 = 3'd4; op1 = 32'h0BAD_F00D; op2 = 32'h0000_0011; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        check("pre_flush_busy", 32'(cur_busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", 32'(cur_ready), 32'd1);
        check("flush_busy", 32'(cur_busy), 32'd0);
        check("flush_valid", 32'(cur_valid), 32'd0);
        check("flush_result", cur_result, prev);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (cur_valid) vcount++; end
        check("flush_no_valid", 32'(vcount), 32'd0);

        // Flush wins over a simultaneous start from DONE
        run_op("mul_pre", 3'd0, 32'h0000_1234, 32'h0000_0010, -1);
        prev = cur_result;
        f3 = 3'd0; op1 = 32'd5; op2 = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_ready", 32'(cur_ready), 32'd1);
        check("flush_start_busy", 32'(cur_busy), 32'd0);
        check("flush_start_valid", 32'(cur_valid), 32'd0);
        check("flush_start_result", cur_result, prev);

        // Reset during FIX
        f3 = 3'd0; op1 = 32'h1111_1111; op2 = 32'h2222_2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 32) begin @(posedge clk); #1; lat++; end
        check("fix_busy", 32'(cur_busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_fix_ready", 32'(cur_ready), 32'd1);
        check("rst_fix_busy", 32'(cur_busy), 32'd0);
        check("rst_fix_valid", 32'(cur_valid), 32'd0);
        check("rst_fix_result", cur_result, 32'd0);
        run_op("mul_after_rst", 3'd0, 32'd7, 32'd6, -1);
        check("mul_after_rst_known", cur_result, 32'h0000_002A);

        // XLEN = 16 directed
        sel16 = 1'b1;
        run_op("mul16",     3'd0, 32'h3FFF, 32'h0003, -1);
        check("mul16_known", cur_result, 32'h0000_BFFD);
        run_op("mulhu16",   3'd3, 32'hFFFF, 32'hFFFF, -1);
        run_op("div16_neg", 3'd4, 32'hFFF9, 32'h0002, -1);
        check("div16_neg_known", cur_result, 32'h0000_FFFD);
        run_op("rem16_neg", 3'd6, 32'hFFF9, 32'h0002, -1);
        run_op("div16_ovf", 3'd4, 32'h8000, 32'hFFFF, -1);
        run_op("remu16_zero", 3'd7, 32'h1234, 32'h0000, -1);

        // Randomized ops on both widths, biased toward divide corner cases
        for (int i = 0; i < 60; i++) begin
            sel16 = (i % 2) == 1;
            m = sel16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            f = 3'($urandom);
            a = $urandom & m;
            b = $urandom & m;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'd1 << (width() - 1); b = m; end
                2: begin a = $urandom_range(0, 20); b = $urandom_range(1, 5); end
                3: b = (32'd0 - $urandom_range(1, 9)) & m;
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle integer multiply/divide unit implementing the full RISC-V M-extension op set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at configurable width. It sits beside the single-cycle ALU in the execute stage and replaces the combinational MUL/DIV paths with an iterative radix-2 datapath. A start/ready/result_valid handshake lets the pipeline stall while the unit is busy. A flush input lets the pipeline kill an in-flight operation.

## Interface
- XLEN, 32, operand and result width (≥ 8, even)
- CNT_W, $clog2(XLEN), iteration counter width (derived; do not override)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready = 1
- flush  input  1  abort any in-flight or completed operation
- funct3_alu  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand1  input  XLEN  multiplicand / dividend, captured on accept
- operand2  input  XLEN  multiplier / divisor, captured on accept
- ready  output  1  unit can accept start (state IDLE or DONE)
- busy  output  1  operation in progress (state CALC or FIX)
- result_valid  output  1  result holds a finished value (state DONE)
- result  output  XLEN  registered result

## Operation
- States: IDLE, CALC, FIX, DONE. ready = IDLE|DONE; busy = CALC|FIX; result_valid = DONE.
- Accept: start & ready at an edge. Operands, funct3_alu, and sign flags are latched. Later input changes have no effect.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: operand1 signed, operand2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Datapath works on magnitudes. Signed operands are converted to absolute value on accept.
- Multiply: shift-add over XLEN iterations into a 2·XLEN product. FIX negates the product if exactly one signed operand was negative.
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide: restoring division, one quotient bit per iteration.
  - FIX negates the quotient if the signs differ (signed ops).
  - FIX gives the remainder the sign of the dividend.
- Special cases are resolved on accept, bypass CALC/FIX, and go straight to DONE:
  - divisor 0: DIV/DIVU → all ones; REM/REMU → operand1.
  - signed overflow (operand1 = 1 followed by XLEN-1 zeros, operand2 = all ones, DIV/REM): DIV → operand1; REM → 0.
- Transitions:
  - IDLE/DONE –accept→ CALC, counter = XLEN-1; or –accept special→ DONE.
  - CALC: one iteration per edge; counter = 0 → FIX.
  - FIX → DONE, result written.
  - DONE holds result until the next accept, flush, or reset.
- start while busy = 1: ignored, no queuing.
- flush: at the next edge, any state → IDLE, result_valid = 0, result unchanged. flush beats start in the same cycle.
- reset: highest priority, any state.

## Timing
- Reset values: state IDLE, ready 1, busy 0, result_valid 0, result 0, counter 0.
- Normal latency: start accepted at edge E; CALC occupies edges E+1 … E+XLEN; FIX at edge E+XLEN+1. result_valid is high after that edge (XLEN+1 edges after accept; 33 for XLEN = 32).
- Special-case latency: result_valid high after edge E.
- Back-to-back: start in DONE is accepted. result_valid drops after that edge, or stays high for a special case with a new result.
- Reset or flush mid-CALC: the partial result is discarded; ready = 1 in the following cycle.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- MUL 0x3FFFFFFF × 0x00000003 → result 0xBFFFFFFD. result_valid rises exactly 33 edges after accept; busy high for 33 cycles.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0x3FFFFFFF / 3 → 0x15555555, REM → 0. DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIVU 0x12345678 / 0 → 0xFFFFFFFF. REMU → 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. Each is valid one edge after accept.
- Start a DIV, pulse start with new operands at CALC cycle 5 → ignored, original result returned. Flush at CALC cycle 10 → IDLE next edge, result_valid never asserts, result keeps its prior value.
- Assert reset during FIX → ready 1, busy 0, result_valid 0, result 0 next cycle. A new MUL 7 × 6 then returns 0x0000002A. Repeat the MUL/DIV cases with XLEN = 16 (e.g. MUL 0x3FFF × 3 → 0xBFFD, 17-edge latency).
